// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer and HI/LO register owner.
//
// Ports:
//   clk, rstn          core clock (rising edge), asynchronous active-low reset
//   i_div, i_divu      start signed / unsigned divide (rs / rt)
//   i_multu            start unsigned multiply (rs * rt)
//   i_mthi, i_mtlo     write rs_data into HI / LO in a single cycle
//   flush              abort the in-flight operation; blocks strobes in IDLE
//   rs_data, rt_data   operands, latched when an operation is accepted
//   hi, lo             HI (remainder / product high) and LO (quotient / product low)
//   busy               high while an iterative operation runs
//   done               one-cycle pulse when results land in HI/LO
//
// Optional feature: define MULDIV_FAST_MUL_EN to give multu a combinational
// WIDTH x WIDTH multiplier that writes HI/LO at the acceptance edge.
module muldiv_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_div,
  input  logic             i_divu,
  input  logic             i_multu,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned W2 = 2 * WIDTH;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Shared accumulator: divide keeps {remainder, dividend/quotient},
  // multiply keeps {partial product high, multiplier/product low}.
  logic [W2-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic            is_mul_q, is_mul_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic            done_q, done_d;

  logic [WIDTH:0]   rem_shift, rem_sub, mul_sum;
  logic [W2-1:0]    div_step, mul_step, step, fast_prod;
  logic [WIDTH-1:0] q_mag, r_mag, res_hi, res_lo, rs_abs, rt_abs;
  logic             last, start_iter;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_mul_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_mul_q <= is_mul_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // One iteration of either engine, plus sign fix-up of the final result.
  always_comb begin
    rem_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, opnd_q};
    if (rem_sub[WIDTH]) div_step = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    else                div_step = {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    step      = is_mul_q ? mul_step : div_step;
    q_mag     = step[WIDTH-1:0];
    r_mag     = step[W2-1:WIDTH];
    if (is_mul_q) begin
      res_hi = r_mag;
      res_lo = q_mag;
    end else begin
      res_hi = rneg_q ? -r_mag : r_mag;
      res_lo = qneg_q ? -q_mag : q_mag;
    end
    rs_abs    = rs_data[WIDTH-1] ? -rs_data : rs_data;
    rt_abs    = rt_data[WIDTH-1] ? -rt_data : rt_data;
    fast_prod = W2'(rs_data) * W2'(rt_data);
    last      = (cnt_q == CW'(WIDTH - 1));
    start_iter = (state_q == IDLE) && !flush &&
                 (i_div || i_divu || (i_multu && !FAST_MUL));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_iter) state_d = RUN;
      RUN:     if (flush || last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_mul_d = is_mul_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (!flush) begin
        if (i_div) begin
          acc_d    = {{WIDTH{1'b0}}, rs_abs};
          opnd_d   = rt_abs;
          is_mul_d = 1'b0;
          // A zero divisor must leave the all-ones raw quotient un-negated;
          // the remainder path already reproduces rs.
          qneg_d   = (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]) && (rt_data != '0);
          rneg_d   = rs_data[WIDTH-1];
        end else if (i_divu) begin
          acc_d    = {{WIDTH{1'b0}}, rs_data};
          opnd_d   = rt_data;
          is_mul_d = 1'b0;
          qneg_d   = 1'b0;
          rneg_d   = 1'b0;
        end else if (i_multu) begin
          if (FAST_MUL) begin
            hi_d   = fast_prod[W2-1:WIDTH];
            lo_d   = fast_prod[WIDTH-1:0];
            done_d = 1'b1;
          end else begin
            acc_d    = {{WIDTH{1'b0}}, rt_data};
            opnd_d   = rs_data;
            is_mul_d = 1'b1;
            qneg_d   = 1'b0;
            rneg_d   = 1'b0;
          end
        end else if (i_mthi) begin
          hi_d = rs_data;
        end else if (i_mtlo) begin
          lo_d = rs_data;
        end
      end
    end else if (!flush) begin
      acc_d = step;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        hi_d   = res_hi;
        lo_d   = res_lo;
        done_d = 1'b1;
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    hi   = hi_q;
    lo   = lo_q;
    done = done_q;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          i_div = 1'b0, i_divu = 1'b0, i_multu = 1'b0, i_mthi = 1'b0, i_mtlo = 1'b0;
  logic          flush = 1'b0;
  logic [W-1:0]  rs_data = '0, rt_data = '0;
  logic [W-1:0]  hi, lo;
  logic          busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .i_div(i_div), .i_divu(i_divu), .i_multu(i_multu),
    .i_mthi(i_mthi), .i_mtlo(i_mtlo), .flush(flush), .rs_data(rs_data),
    .rt_data(rt_data), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}. op 0=div, 1=divu, 2=multu.
  function automatic logic [63:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    if (op == 2) begin
      p = {32'b0, a} * {32'b0, b};
      return p;
    end
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (op == 1) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level model: result computed at acceptance, delivered after W edges.
  logic [W-1:0] m_hi, m_lo, m_rhi, m_rlo;
  logic         m_busy, m_done;
  int           m_left;

  always @(posedge clk or negedge rstn) begin : model
    logic [63:0] r;
    int op;
    if (!rstn) begin
      m_hi <= '0; m_lo <= '0; m_rhi <= '0; m_rlo <= '0;
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (flush) m_busy <= 1'b0;
        else if (m_left == 1) begin
          m_busy <= 1'b0; m_hi <= m_rhi; m_lo <= m_rlo; m_done <= 1'b1; m_left <= 0;
        end else m_left <= m_left - 1;
      end else if (!flush) begin
        if (i_div || i_divu || i_multu) begin
          op = i_div ? 0 : (i_divu ? 1 : 2);
          r  = ref_op(op, rs_data, rt_data);
          if (op == 2 && FAST) begin
            m_hi <= r[63:32]; m_lo <= r[31:0]; m_done <= 1'b1;
          end else begin
            m_rhi <= r[63:32]; m_rlo <= r[31:0]; m_busy <= 1'b1; m_left <= W;
          end
        end else if (i_mthi) m_hi <= rs_data;
        else if (i_mtlo) m_lo <= rs_data;
      end
    end
  end

  always @(negedge clk) begin
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
  end

  always @(posedge clk) begin
    if (rstn && busy)
      assert (!(i_div || i_divu || i_multu || i_mthi || i_mtlo))
        else $error("strobe driven while busy");
  end

  // stb = {div, divu, multu, mthi, mtlo}
  task automatic run_op(input logic [4:0] stb, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, output int bcyc, output int dpul);
    bcyc = 0;
    dpul = 0;
    @(posedge clk); #1;
    {i_div, i_divu, i_multu, i_mthi, i_mtlo} = stb;
    rs_data = a;
    rt_data = b;
    @(posedge clk); #1;
    {i_div, i_divu, i_multu, i_mthi, i_mtlo} = '0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (done) dpul++;
      if (!busy && !done) begin
        flush = 1'b0;
        return;
      end
      flush   = (n == flush_at);
      rs_data = $urandom;
      rt_data = $urandom;
    end
    flush = 1'b0;
    check("op_timeout", 64'(1), 64'(0));
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin : stim
    int b, d, k, fa;
    logic [4:0] stb;

    #1 rstn = 1'b0;
    #2;
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    run_op(5'b01000, 32'd100, 32'd7, 0, b, d);
    check("divu_busy_cycles", 64'(b), 64'd32);
    check("divu_done_pulses", 64'(d), 64'd1);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);

    run_op(5'b10000, 32'hFFFF_FFF9, 32'd2, 0, b, d);
    check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

    run_op(5'b10000, 32'h8000_0000, 32'hFFFF_FFFF, 0, b, d);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(hi), 64'h0);

    run_op(5'b01000, 32'h1234_5678, 32'h0, 0, b, d);
    check("div0_busy_cycles", 64'(b), 64'd32);
    check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    check("div0_hi", 64'(hi), 64'h1234_5678);

    run_op(5'b00100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, b, d);
    check("mul_busy_cycles", 64'(b), FAST ? 64'd0 : 64'd32);
    check("mul_done_pulses", 64'(d), 64'd1);
    check("mul_hi", 64'(hi), 64'hFFFF_FFFE);
    check("mul_lo", 64'(lo), 64'h0000_0001);

    run_op(5'b00010, 32'hA, 32'h0, 0, b, d);
    run_op(5'b00001, 32'hB, 32'h0, 0, b, d);
    check("mthi_busy", 64'(b), 64'd0);
    check("mtx_hi", 64'(hi), 64'hA);
    check("mtx_lo", 64'(lo), 64'hB);

    run_op(5'b01000, 32'd1000, 32'd3, 10, b, d);
    check("flush_busy_cycles", 64'(b), 64'd10);
    check("flush_no_done", 64'(d), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi", 64'(hi), 64'hA);
    check("flush_lo", 64'(lo), 64'hB);
    run_op(5'b00010, 32'h55, 32'h0, 0, b, d);
    check("mthi_after_flush_hi", 64'(hi), 64'h55);
    check("mthi_after_flush_lo", 64'(lo), 64'hB);

    // flush in IDLE swallows a simultaneous strobe
    @(posedge clk); #1;
    flush = 1'b1; i_divu = 1'b1; rs_data = 32'd50; rt_data = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0; i_divu = 1'b0;
    check("idle_flush_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_flush_lo", 64'(lo), 64'hB);

    // asynchronous reset in the middle of a divide
    @(posedge clk); #1;
    i_div = 1'b1; rs_data = 32'd1000; rt_data = 32'd7;
    @(posedge clk); #1;
    i_div = 1'b0;
    repeat (14) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'h0);
    check("arst_lo", 64'(lo), 64'h0);
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_done", 64'(done), 64'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_op(5'b01000, 32'd9, 32'd3, 0, b, d);
    check("post_rst_lo", 64'(lo), 64'd3);
    check("post_rst_hi", 64'(hi), 64'd0);

    // randomized traffic, checked every cycle by the model compare
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: stb = 5'b10000;
        3, 4:    stb = 5'b01000;
        5, 6:    stb = 5'b00100;
        7:       stb = 5'b00010;
        8:       stb = 5'b00001;
        default: stb = 5'($urandom_range(1, 31));
      endcase
      fa = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 34) : 0;
      run_op(stb, pick_val(), pick_val(), fa, b, d);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
